// File: rtl/axilite_addr_decoder.sv
// 1-master to 2-slave AXI4-Lite router; unmapped addresses complete locally with DECERR.
// Optional slave watchdog (SLVERR on stall) enabled by defining AXILITE_DECODER_TIMEOUT_EN.
module axilite_addr_decoder #(
    parameter int unsigned        ADDR_W         = 32,
    parameter int unsigned        DATA_W         = 32,
    parameter logic [ADDR_W-1:0]  S0_BASE        = 32'h4060_0000,
    parameter logic [ADDR_W-1:0]  S0_MASK        = 32'hFFFF_0000,
    parameter logic [ADDR_W-1:0]  S1_BASE        = 32'h4000_0000,
    parameter logic [ADDR_W-1:0]  S1_MASK        = 32'hFFFF_0000,
    parameter int unsigned        TIMEOUT_CYCLES = 1024
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [ADDR_W-1:0]     m0_axi_awaddr,
    output logic                  m0_axi_awvalid,
    input  logic                  m0_axi_awready,
    output logic [DATA_W-1:0]     m0_axi_wdata,
    output logic [DATA_W/8-1:0]   m0_axi_wstrb,
    output logic                  m0_axi_wvalid,
    input  logic                  m0_axi_wready,
    input  logic [1:0]            m0_axi_bresp,
    input  logic                  m0_axi_bvalid,
    output logic                  m0_axi_bready,
    output logic [ADDR_W-1:0]     m0_axi_araddr,
    output logic                  m0_axi_arvalid,
    input  logic                  m0_axi_arready,
    input  logic [DATA_W-1:0]     m0_axi_rdata,
    input  logic [1:0]            m0_axi_rresp,
    input  logic                  m0_axi_rvalid,
    output logic                  m0_axi_rready,
    output logic [ADDR_W-1:0]     m1_axi_awaddr,
    output logic                  m1_axi_awvalid,
    input  logic                  m1_axi_awready,
    output logic [DATA_W-1:0]     m1_axi_wdata,
    output logic [DATA_W/8-1:0]   m1_axi_wstrb,
    output logic                  m1_axi_wvalid,
    input  logic                  m1_axi_wready,
    input  logic [1:0]            m1_axi_bresp,
    input  logic                  m1_axi_bvalid,
    output logic                  m1_axi_bready,
    output logic [ADDR_W-1:0]     m1_axi_araddr,
    output logic                  m1_axi_arvalid,
    input  logic                  m1_axi_arready,
    input  logic [DATA_W-1:0]     m1_axi_rdata,
    input  logic [1:0]            m1_axi_rresp,
    input  logic                  m1_axi_rvalid,
    output logic                  m1_axi_rready
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE, W_FWD, W_RESP, B_OUT, R_FWD, R_WAIT, R_OUT
    } state_e;

    state_e              state_q, state_d;
    logic                sel_q, sel_d;
    logic                awready_q, awready_d;
    logic                wready_q, wready_d;
    logic                arready_q, arready_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic aw_hit0, aw_hit1, ar_hit0, ar_hit1;
    assign aw_hit0 = (s_axi_awaddr & S0_MASK) == S0_BASE;
    assign aw_hit1 = (s_axi_awaddr & S1_MASK) == S1_BASE;
    assign ar_hit0 = (s_axi_araddr & S0_MASK) == S0_BASE;
    assign ar_hit1 = (s_axi_araddr & S1_MASK) == S1_BASE;

    logic              sl_awready, sl_wready, sl_bvalid, sl_arready, sl_rvalid;
    logic [1:0]        sl_bresp, sl_rresp;
    logic [DATA_W-1:0] sl_rdata;
    assign sl_awready = sel_q ? m1_axi_awready : m0_axi_awready;
    assign sl_wready  = sel_q ? m1_axi_wready  : m0_axi_wready;
    assign sl_bvalid  = sel_q ? m1_axi_bvalid  : m0_axi_bvalid;
    assign sl_bresp   = sel_q ? m1_axi_bresp   : m0_axi_bresp;
    assign sl_arready = sel_q ? m1_axi_arready : m0_axi_arready;
    assign sl_rvalid  = sel_q ? m1_axi_rvalid  : m0_axi_rvalid;
    assign sl_rresp   = sel_q ? m1_axi_rresp   : m0_axi_rresp;
    assign sl_rdata   = sel_q ? m1_axi_rdata   : m0_axi_rdata;

`ifdef AXILITE_DECODER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             busy, tmo_hit;
    assign busy    = state_q inside {W_FWD, W_RESP, R_FWD, R_WAIT};
    assign tmo_hit = busy && (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign tmo_d   = busy ? tmo_q + 1'b1 : '0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) tmo_q <= '0;
        else          tmo_q <= tmo_d;
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    // Ready pulses are registered: they rise the cycle after the request is
    // seen and the handshake edge is the one that latches the transaction.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        arready_d = 1'b0;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (awready_q) begin
                    addr_d    = s_axi_awaddr;
                    wdata_d   = s_axi_wdata;
                    wstrb_d   = s_axi_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (aw_hit0 || aw_hit1) begin
                        sel_d   = !aw_hit0;
                        state_d = W_FWD;
                    end else begin
                        bresp_d = RESP_DECERR;
                        state_d = B_OUT;
                    end
                end else if (arready_q) begin
                    addr_d = s_axi_araddr;
                    if (ar_hit0 || ar_hit1) begin
                        sel_d   = !ar_hit0;
                        state_d = R_FWD;
                    end else begin
                        rresp_d = RESP_DECERR;
                        rdata_d = '0;
                        state_d = R_OUT;
                    end
                end else if (s_axi_awvalid && s_axi_wvalid) begin
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end else if (s_axi_arvalid) begin
                    arready_d = 1'b1;
                end
            end
            W_FWD: begin
                if (sl_awready) aw_done_d = 1'b1;
                if (sl_wready)  w_done_d  = 1'b1;
                if ((aw_done_q || sl_awready) && (w_done_q || sl_wready))
                    state_d = W_RESP;
            end
            W_RESP: begin
                if (sl_bvalid) begin
                    bresp_d = sl_bresp;
                    state_d = B_OUT;
                end
            end
            B_OUT: begin
                if (s_axi_bready) state_d = IDLE;
            end
            R_FWD: begin
                if (sl_arready) state_d = R_WAIT;
            end
            R_WAIT: begin
                if (sl_rvalid) begin
                    rdata_d = sl_rdata;
                    rresp_d = sl_rresp;
                    state_d = R_OUT;
                end
            end
            R_OUT: begin
                if (s_axi_rready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef AXILITE_DECODER_TIMEOUT_EN
        if (tmo_hit) begin
            if (state_q == W_FWD || state_q == W_RESP) begin
                bresp_d = RESP_SLVERR;
                state_d = B_OUT;
            end else begin
                rresp_d = RESP_SLVERR;
                rdata_d = '0;
                state_d = R_OUT;
            end
        end
`endif
    end

    always_comb begin
        m0_axi_awvalid = 1'b0;
        m0_axi_wvalid  = 1'b0;
        m0_axi_bready  = 1'b0;
        m0_axi_arvalid = 1'b0;
        m0_axi_rready  = 1'b0;
        m1_axi_awvalid = 1'b0;
        m1_axi_wvalid  = 1'b0;
        m1_axi_bready  = 1'b0;
        m1_axi_arvalid = 1'b0;
        m1_axi_rready  = 1'b0;
        unique case (state_q)
            W_FWD: begin
                m0_axi_awvalid = !sel_q && !aw_done_q;
                m1_axi_awvalid =  sel_q && !aw_done_q;
                m0_axi_wvalid  = !sel_q && !w_done_q;
                m1_axi_wvalid  =  sel_q && !w_done_q;
            end
            W_RESP: begin
                m0_axi_bready = !sel_q;
                m1_axi_bready =  sel_q;
            end
            R_FWD: begin
                m0_axi_arvalid = !sel_q;
                m1_axi_arvalid =  sel_q;
            end
            R_WAIT: begin
                m0_axi_rready = !sel_q;
                m1_axi_rready =  sel_q;
            end
            default: ;
        endcase
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_arready = arready_q;
    assign s_axi_bvalid  = (state_q == B_OUT);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = (state_q == R_OUT);
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;

    assign m0_axi_awaddr = addr_q;
    assign m0_axi_araddr = addr_q;
    assign m0_axi_wdata  = wdata_q;
    assign m0_axi_wstrb  = wstrb_q;
    assign m1_axi_awaddr = addr_q;
    assign m1_axi_araddr = addr_q;
    assign m1_axi_wdata  = wdata_q;
    assign m1_axi_wstrb  = wstrb_q;

endmodule

// File: tb/tb_axilite_addr_decoder.sv
// Bench for axilite_addr_decoder: behavioural slaves on both ports plus a
// response scoreboard on the upstream side.
`timescale 1ns/1ps
module tb_axilite_addr_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;
    logic awvalid = 0, wvalid = 0, arvalid = 0, bready = 0, rready = 0;
    logic awready, wready, arready, bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    logic [31:0] m_awaddr[2], m_araddr[2], m_wdata[2], m_rdata[2];
    logic [3:0]  m_wstrb[2];
    logic m_awvalid[2], m_wvalid[2], m_arvalid[2], m_bready[2], m_rready[2];
    logic m_awready[2], m_wready[2], m_arready[2], m_bvalid[2], m_rvalid[2];
    logic [1:0]  m_bresp[2], m_rresp[2];

    // slave behaviour knobs
    int          aw_wait[2], w_wait[2], ar_wait[2], r_wait[2];
    bit          ar_never[2];
    logic [31:0] s_rdata[2];
    logic [1:0]  s_rresp[2], s_bresp[2];

    // slave state
    int aw_cnt[2], w_cnt[2], ar_cnt[2], r_cnt[2];
    bit aw_got[2], w_got[2], r_pend[2];

    // observations
    int          n_aw[2], n_w[2], n_ar[2], awv_cyc[2], wv_cyc[2], first_awv[2];
    logic [31:0] cap_awaddr[2], cap_wdata[2], cap_araddr[2];
    logic [3:0]  cap_wstrb[2];
    bit          act[2];
    int          aw_cyc, ar_cyc, b_cyc, r_cyc;

    logic [1:0]  exp_b[$], got_b[$];
    logic [33:0] exp_r[$], got_r[$];

    axilite_addr_decoder #(.TIMEOUT_CYCLES(16)) dut (
        .aclk(clk), .aresetn(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready), .s_axi_araddr(araddr), .s_axi_arvalid(arvalid),
        .s_axi_arready(arready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .m0_axi_awaddr(m_awaddr[0]), .m0_axi_awvalid(m_awvalid[0]),
        .m0_axi_awready(m_awready[0]), .m0_axi_wdata(m_wdata[0]),
        .m0_axi_wstrb(m_wstrb[0]), .m0_axi_wvalid(m_wvalid[0]),
        .m0_axi_wready(m_wready[0]), .m0_axi_bresp(m_bresp[0]),
        .m0_axi_bvalid(m_bvalid[0]), .m0_axi_bready(m_bready[0]),
        .m0_axi_araddr(m_araddr[0]), .m0_axi_arvalid(m_arvalid[0]),
        .m0_axi_arready(m_arready[0]), .m0_axi_rdata(m_rdata[0]),
        .m0_axi_rresp(m_rresp[0]), .m0_axi_rvalid(m_rvalid[0]),
        .m0_axi_rready(m_rready[0]),
        .m1_axi_awaddr(m_awaddr[1]), .m1_axi_awvalid(m_awvalid[1]),
        .m1_axi_awready(m_awready[1]), .m1_axi_wdata(m_wdata[1]),
        .m1_axi_wstrb(m_wstrb[1]), .m1_axi_wvalid(m_wvalid[1]),
        .m1_axi_wready(m_wready[1]), .m1_axi_bresp(m_bresp[1]),
        .m1_axi_bvalid(m_bvalid[1]), .m1_axi_bready(m_bready[1]),
        .m1_axi_araddr(m_araddr[1]), .m1_axi_arvalid(m_arvalid[1]),
        .m1_axi_arready(m_arready[1]), .m1_axi_rdata(m_rdata[1]),
        .m1_axi_rresp(m_rresp[1]), .m1_axi_rvalid(m_rvalid[1]),
        .m1_axi_rready(m_rready[1])
    );

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            m_awready[k] = m_awvalid[k] && (aw_cnt[k] >= aw_wait[k]);
            m_wready[k]  = m_wvalid[k] && (w_cnt[k] >= w_wait[k]);
            m_arready[k] = m_arvalid[k] && !ar_never[k] && (ar_cnt[k] >= ar_wait[k]);
            m_bvalid[k]  = aw_got[k] && w_got[k];
            m_bresp[k]   = m_bvalid[k] ? s_bresp[k] : 2'b00;
            m_rvalid[k]  = r_pend[k] && (r_cnt[k] >= r_wait[k]);
            m_rresp[k]   = m_rvalid[k] ? s_rresp[k] : 2'b00;
            m_rdata[k]   = m_rvalid[k] ? s_rdata[k] : 32'h0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                aw_cnt[k] <= 0; w_cnt[k] <= 0; ar_cnt[k] <= 0; r_cnt[k] <= 0;
                aw_got[k] <= 0; w_got[k] <= 0; r_pend[k] <= 0;
            end else begin
                if (m_bvalid[k] && m_bready[k]) begin
                    aw_got[k] <= 0; w_got[k] <= 0;
                end
                if (m_awvalid[k] && m_awready[k]) begin
                    aw_got[k] <= 1; aw_cnt[k] <= 0;
                end else if (m_awvalid[k]) aw_cnt[k] <= aw_cnt[k] + 1;
                if (m_wvalid[k] && m_wready[k]) begin
                    w_got[k] <= 1; w_cnt[k] <= 0;
                end else if (m_wvalid[k]) w_cnt[k] <= w_cnt[k] + 1;
                if (m_arvalid[k] && m_arready[k]) begin
                    r_pend[k] <= 1; r_cnt[k] <= 0; ar_cnt[k] <= 0;
                end else if (m_arvalid[k]) ar_cnt[k] <= ar_cnt[k] + 1;
                if (m_rvalid[k] && m_rready[k]) r_pend[k] <= 0;
                else if (r_pend[k] && !m_rvalid[k]) r_cnt[k] <= r_cnt[k] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (awready) aw_cyc = cyc;
        if (arready) ar_cyc = cyc;
        if (bvalid && bready) begin got_b.push_back(bresp); b_cyc = cyc; end
        if (rvalid && rready) begin got_r.push_back({rresp, rdata}); r_cyc = cyc; end
        for (int k = 0; k < 2; k++) begin
            if (m_awvalid[k] || m_wvalid[k] || m_arvalid[k] || m_bready[k] || m_rready[k])
                act[k] = 1;
            if (m_awvalid[k]) begin
                awv_cyc[k]++;
                if (first_awv[k] < 0) first_awv[k] = cyc;
            end
            if (m_wvalid[k]) wv_cyc[k]++;
            if (m_awvalid[k] && m_awready[k]) begin
                n_aw[k]++; cap_awaddr[k] = m_awaddr[k];
            end
            if (m_wvalid[k] && m_wready[k]) begin
                n_w[k]++; cap_wdata[k] = m_wdata[k]; cap_wstrb[k] = m_wstrb[k];
            end
            if (m_arvalid[k] && m_arready[k]) begin
                n_ar[k]++; cap_araddr[k] = m_araddr[k];
            end
        end
    end

    task automatic clear_obs();
        for (int k = 0; k < 2; k++) begin
            n_aw[k] = 0; n_w[k] = 0; n_ar[k] = 0; act[k] = 0;
            awv_cyc[k] = 0; wv_cyc[k] = 0; first_awv[k] = -1;
            aw_wait[k] = 0; w_wait[k] = 0; ar_wait[k] = 0; r_wait[k] = 0;
            ar_never[k] = 0; s_bresp[k] = 2'b00; s_rresp[k] = 2'b00;
            s_rdata[k] = 32'h0;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] er);
        int n;
        exp_b.push_back(er);
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 64);
        if (!awready) begin
            total++; bad++;
            $display("FAIL wr_accept: awready=%b required 1 within 64 cycles", awready);
        end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; bready = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bvalid && n < 2000);
        if (!bvalid) begin
            total++; bad++;
            $display("FAIL wr_resp: bvalid=%b required 1 within 2000 cycles", bvalid);
        end
        @(posedge clk); #1;
        bready = 0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [33:0] er);
        int n;
        exp_r.push_back(er);
        @(posedge clk); #1;
        araddr = a; arvalid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 64);
        if (!arready) begin
            total++; bad++;
            $display("FAIL rd_accept: arready=%b required 1 within 64 cycles", arready);
        end
        @(posedge clk); #1;
        arvalid = 0; rready = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rvalid && n < 2000);
        if (!rvalid) begin
            total++; bad++;
            $display("FAIL rd_resp: rvalid=%b required 1 within 2000 cycles", rvalid);
        end
        @(posedge clk); #1;
        rready = 0;
    endtask

    function automatic logic any_out();
        return |{awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata,
                 m_awvalid[0], m_wvalid[0], m_arvalid[0], m_bready[0], m_rready[0],
                 m_awvalid[1], m_wvalid[1], m_arvalid[1], m_bready[1], m_rready[1],
                 m_awaddr[0], m_araddr[0], m_wdata[0], m_wstrb[0],
                 m_awaddr[1], m_araddr[1], m_wdata[1], m_wstrb[1]};
    endfunction

    task automatic test_reset();
        logic o;
        repeat (3) @(negedge clk);
        o = any_out();
        total++;
        if (o !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: got %b required 0", o);
        end
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_write_hit();
        logic [1:0] e, g;
        clear_obs();
        do_write(32'h4060_0004, 32'h0000_0041, 4'hF, 2'b00);
        total++;
        if (got_b.size() == 0) begin
            bad++; $display("FAIL wr_hit_resp: got none required 1 response");
        end else begin
            e = exp_b.pop_front(); g = got_b.pop_front();
            if (g !== e) begin bad++; $display("FAIL wr_hit_resp: got %b required %b", g, e); end
        end
        total++;
        if (n_aw[0] !== 1 || n_w[0] !== 1) begin
            bad++; $display("FAIL wr_hit_once: aw=%0d w=%0d required 1 1", n_aw[0], n_w[0]);
        end
        total++;
        if ({cap_awaddr[0], cap_wdata[0], cap_wstrb[0]} !== {32'h4060_0004, 32'h41, 4'hF}) begin
            bad++;
            $display("FAIL wr_hit_fields: got %h %h %h required 40600004 00000041 f",
                     cap_awaddr[0], cap_wdata[0], cap_wstrb[0]);
        end
        total++;
        if (act[1] !== 1'b0) begin
            bad++; $display("FAIL wr_hit_m1_idle: act=%b required 0", act[1]);
        end
        total++;
        if (first_awv[0] - aw_cyc !== 1) begin
            bad++; $display("FAIL wr_hit_fwd_lat: got %0d required 1", first_awv[0] - aw_cyc);
        end
        total++;
        if (b_cyc - aw_cyc !== 3) begin
            bad++; $display("FAIL wr_hit_b_lat: got %0d required 3", b_cyc - aw_cyc);
        end
    endtask

    task automatic test_read_wait();
        logic [33:0] e, g;
        clear_obs();
        r_wait[1] = 5; s_rdata[1] = 32'hDEAD_BEEF; s_rresp[1] = 2'b00;
        do_read(32'h4000_0008, {2'b00, 32'hDEAD_BEEF});
        total++;
        if (got_r.size() == 0) begin
            bad++; $display("FAIL rd_wait_resp: got none required 1 response");
        end else begin
            e = exp_r.pop_front(); g = got_r.pop_front();
            if (g !== e) begin bad++; $display("FAIL rd_wait_resp: got %h required %h", g, e); end
        end
        total++;
        if (n_ar[1] !== 1 || cap_araddr[1] !== 32'h4000_0008) begin
            bad++; $display("FAIL rd_wait_ar: n=%0d addr=%h required 1 40000008", n_ar[1], cap_araddr[1]);
        end
        total++;
        if (act[0] !== 1'b0) begin
            bad++; $display("FAIL rd_wait_m0_idle: act=%b required 0", act[0]);
        end
    endtask

    task automatic test_miss();
        logic [1:0] eb, gb;
        logic [33:0] er, gr;
        clear_obs();
        do_write(32'h1234_0000, 32'hCAFE_0001, 4'h3, 2'b11);
        total++;
        if (b_cyc - aw_cyc !== 1) begin
            bad++; $display("FAIL miss_b_lat: got %0d required 1", b_cyc - aw_cyc);
        end
        do_read(32'h1234_0000, {2'b11, 32'h0});
        total++;
        if (got_b.size() == 0 || got_r.size() == 0) begin
            bad++; $display("FAIL miss_resp: b=%0d r=%0d required 1 1", got_b.size(), got_r.size());
        end else begin
            eb = exp_b.pop_front(); gb = got_b.pop_front();
            er = exp_r.pop_front(); gr = got_r.pop_front();
            if (gb !== eb || gr !== er) begin
                bad++; $display("FAIL miss_resp: got %b %h required %b %h", gb, gr, eb, er);
            end
        end
        total++;
        if (act[0] !== 1'b0 || act[1] !== 1'b0) begin
            bad++; $display("FAIL miss_no_fwd: act0=%b act1=%b required 0 0", act[0], act[1]);
        end
    endtask

    task automatic test_priority();
        logic [1:0] eb, gb;
        logic [33:0] er, gr;
        clear_obs();
        s_rdata[0] = 32'h1234_5678;
        fork
            do_write(32'h4060_0010, 32'hA5A5_5A5A, 4'h5, 2'b00);
            do_read(32'h4060_0020, {2'b00, 32'h1234_5678});
        join
        total++;
        if (!(ar_cyc > b_cyc)) begin
            bad++; $display("FAIL prio_order: arready cyc %0d required after bvalid cyc %0d", ar_cyc, b_cyc);
        end
        total++;
        if (got_b.size() == 0 || got_r.size() == 0) begin
            bad++; $display("FAIL prio_resp: b=%0d r=%0d required 1 1", got_b.size(), got_r.size());
        end else begin
            eb = exp_b.pop_front(); gb = got_b.pop_front();
            er = exp_r.pop_front(); gr = got_r.pop_front();
            if (gb !== eb || gr !== er) begin
                bad++; $display("FAIL prio_resp: got %b %h required %b %h", gb, gr, eb, er);
            end
        end
        total++;
        if (cap_awaddr[0] !== 32'h4060_0010 || cap_araddr[0] !== 32'h4060_0020) begin
            bad++; $display("FAIL prio_addr: got %h %h required 40600010 40600020", cap_awaddr[0], cap_araddr[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] e, g;
        clear_obs();
        s_bresp[1] = 2'b10;
        do_write(32'h4000_0100, 32'h1111_1111, 4'hF, 2'b10);
        s_bresp[1] = 2'b00;
        do_write(32'h4000_0104, 32'h2222_2222, 4'hC, 2'b00);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (got_b.size() == 0) begin
                bad++; $display("FAIL b2b_resp%0d: got none required 1 response", i);
            end else begin
                e = exp_b.pop_front(); g = got_b.pop_front();
                if (g !== e) begin bad++; $display("FAIL b2b_resp%0d: got %b required %b", i, g, e); end
            end
        end
        total++;
        if (n_aw[1] !== 2 || cap_wdata[1] !== 32'h2222_2222 || cap_wstrb[1] !== 4'hC) begin
            bad++; $display("FAIL b2b_fwd: n=%0d data=%h strb=%h required 2 22222222 c", n_aw[1], cap_wdata[1], cap_wstrb[1]);
        end
    endtask

    task automatic test_stall_and_reset();
        logic o;
        logic [33:0] e, g;
        int n;
        clear_obs();
        aw_wait[0] = 3;
        do_write(32'h4060_0008, 32'h0000_0055, 4'h1, 2'b00);
        void'(exp_b.pop_front()); void'(got_b.pop_front());
        total++;
        if (awv_cyc[0] !== 4 || wv_cyc[0] !== 1) begin
            bad++; $display("FAIL stall_valids: aw=%0d w=%0d required 4 1", awv_cyc[0], wv_cyc[0]);
        end
        clear_obs();
        r_wait[1] = 1000;
        @(posedge clk); #1;
        araddr = 32'h4000_0040; arvalid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 64);
        @(posedge clk); #1;
        arvalid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!m_rready[1] && n < 64);
        total++;
        if (m_rready[1] !== 1'b1) begin
            bad++; $display("FAIL rst_rwait: m1_rready=%b required 1", m_rready[1]);
        end
        #1 rst_n = 0;
        #1 o = any_out();
        total++;
        if (o !== 1'b0) begin
            bad++; $display("FAIL rst_async_outputs: got %b required 0", o);
        end
        @(posedge clk); #1;
        rst_n = 1;
        r_wait[1] = 0; s_rdata[1] = 32'h0BAD_F00D;
        do_read(32'h4000_0044, {2'b00, 32'h0BAD_F00D});
        total++;
        if (got_r.size() != 1) begin
            bad++; $display("FAIL rst_after_resp: got %0d responses required 1", got_r.size());
        end else begin
            e = exp_r.pop_front(); g = got_r.pop_front();
            if (g !== e) begin bad++; $display("FAIL rst_after_resp: got %h required %h", g, e); end
        end
    endtask

`ifdef AXILITE_DECODER_TIMEOUT_EN
    task automatic test_timeout();
        logic [33:0] e, g;
        clear_obs();
        ar_never[1] = 1; s_rdata[1] = 32'hFFFF_FFFF;
        do_read(32'h4000_0000, {2'b10, 32'h0});
        total++;
        if (got_r.size() == 0) begin
            bad++; $display("FAIL tmo_resp: got none required 1 response");
        end else begin
            e = exp_r.pop_front(); g = got_r.pop_front();
            if (g !== e) begin bad++; $display("FAIL tmo_resp: got %h required %h", g, e); end
        end
        total++;
        if (r_cyc - ar_cyc !== 17) begin
            bad++; $display("FAIL tmo_lat: got %0d required 17", r_cyc - ar_cyc);
        end
        total++;
        if (m_arvalid[1] !== 1'b0) begin
            bad++; $display("FAIL tmo_drop: m1_arvalid=%b required 0", m_arvalid[1]);
        end
    endtask
`endif

    initial begin
        clear_obs();
        test_reset();
        test_write_hit();
        test_read_wait();
        test_miss();
        test_priority();
        test_back_to_back();
        test_stall_and_reset();
`ifdef AXILITE_DECODER_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axilite_addr_decoder.md
Name: axilite_addr_decoder

Overview:
- 1-master-to-2-slave AXI4-Lite address decoder/router between the JTAG-to-AXI-Lite master and the memory-mapped peripherals.
- Port 0 serves the UART-lite slave; port 1 is for the next peripheral (GPIO/LED).
- Handles one transaction at a time, registered on all paths.
- Unmapped addresses complete locally with DECERR, so the JTAG master never hangs.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; WSTRB width = DATA_W/8.
- S0_BASE, 32'h4060_0000, port 0 base.
- S0_MASK, 32'hFFFF_0000, port 0 compare mask.
- S1_BASE, 32'h4000_0000, port 1 base.
- S1_MASK, 32'hFFFF_0000, port 1 compare mask.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- aclk  in  1  clock, 100 MHz
- aresetn  in  1  asynchronous active-low reset
- s_axi_awaddr, s_axi_araddr  in  ADDR_W  upstream addresses
- s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, s_axi_bready, s_axi_rready  in  1  upstream handshakes
- s_axi_wdata  in  DATA_W  upstream write data
- s_axi_wstrb  in  DATA_W/8  upstream write strobes
- s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid  out  1  upstream handshakes
- s_axi_bresp, s_axi_rresp  out  2  upstream responses
- s_axi_rdata  out  DATA_W  upstream read data
- mK_axi_awaddr, mK_axi_araddr  out  ADDR_W  slave K addresses, K = 0,1
- mK_axi_wdata  out  DATA_W  slave K write data
- mK_axi_wstrb  out  DATA_W/8  slave K write strobes
- mK_axi_awvalid, mK_axi_wvalid, mK_axi_arvalid, mK_axi_bready, mK_axi_rready  out  1  slave K handshakes
- mK_axi_awready, mK_axi_wready, mK_axi_arready, mK_axi_bvalid, mK_axi_rvalid  in  1  slave K handshakes
- mK_axi_bresp, mK_axi_rresp  in  2  slave K responses
- mK_axi_rdata  in  DATA_W  slave K read data

Behaviour:
- Reset (async assert, sync deassert assumed upstream): FSM to IDLE; every valid/ready output 0; every data, address and response output 0. Reset mid-transaction abandons it; no response is issued.
- Decode: hitK = ((addr & SK_MASK) == SK_BASE). Port 0 wins if both hit. No hit = miss.
- FSM states: IDLE, W_FWD, W_RESP, B_OUT, R_FWD, R_WAIT, R_OUT.
- IDLE, write accept: when s_axi_awvalid && s_axi_wvalid, pulse awready and wready for 1 cycle; latch addr/data/strb and decode result.
  - Write has priority over a simultaneous arvalid; the read stays pending.
  - AW without W (or W without AW) is not accepted.
- IDLE, read accept: when arvalid and no write is pending, pulse arready; latch addr.
- W_FWD: assert mK awvalid and wvalid together. Drop each one independently on its own ready. When both have completed, go to W_RESP.
- W_RESP: assert mK bready; on mK bvalid, latch bresp and go to B_OUT.
- B_OUT: hold s_axi_bvalid with the latched bresp until s_axi_bready, then go to IDLE.
- R_FWD: assert mK arvalid until arready, then go to R_WAIT.
- R_WAIT: assert mK rready until rvalid; latch rdata/rresp and go to R_OUT.
- R_OUT: hold s_axi_rvalid until s_axi_rready, then go to IDLE.
- Miss: go from IDLE directly to B_OUT with bresp=2'b11, or to R_OUT with rresp=2'b11 and rdata=0. s_axi_bvalid/rvalid are asserted the cycle after accept.
- Latency, hit with zero-wait slave: accept at cycle 0; downstream valid at cycle 1; s_axi_bvalid/rvalid at cycle 3.
- Ready/valid pass-through: no combinational paths from any m*_ready/valid to any s_axi_* output.
- Non-selected port: all valids and readies held 0.
- Back-to-back: the next accept is possible the cycle after returning to IDLE.

Optional Feature:
- Macro AXILITE_DECODER_TIMEOUT_EN.
- Defined: a counter clears on entry to W_FWD or R_FWD. It counts every cycle spent in W_FWD/W_RESP/R_FWD/R_WAIT. At TIMEOUT_CYCLES, all downstream valids/readies drop, and the block goes to B_OUT/R_OUT with resp=2'b10 (SLVERR) and rdata=0.
- Undefined: no counter; the block waits indefinitely for the slave.

Test Plan:
- Write 0x4060_0004 data 0x0000_0041 strb 0xF, slave 0 zero-wait, bresp OKAY -> m0 sees addr/data/strb exactly once; s_axi_bresp=2'b00; m1 idle; s_axi_bvalid at cycle 3.
- Read 0x4000_0008, slave 1 returns rdata 0xDEAD_BEEF after 5 wait cycles -> s_axi_rdata=0xDEAD_BEEF, rresp=2'b00; m0 untouched.
- Write then read to 0x1234_0000 (miss) -> bresp=2'b11, then rresp=2'b11 with rdata=0; no m0/m1 valids ever asserted.
- awvalid, wvalid and arvalid asserted the same cycle to port 0 -> write completes first, then read; arready stays 0 until the write reaches IDLE.
- Slave holds awready low 3 cycles while wready is immediate; reset asserted during R_WAIT -> wvalid drops alone after 1 cycle and awvalid after 4; on reset all outputs go to 0 immediately and the next transaction completes normally.
- AXILITE_DECODER_TIMEOUT_EN with TIMEOUT_CYCLES=16, slave never asserts arready -> s_axi_rvalid with rresp=2'b10 and rdata=0 after 16 cycles in R_FWD.
